word_narrow_16: RTL and testbench

WORD_NARROW_16 -- requirements
Module: word_narrow_16

---
 rtl/word_narrow_16.sv | 155 +++++++++++++++
 tb/tb_word_narrow_16.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/word_narrow_16.sv
// word_narrow_16: accepts a 32-bit word and emits it on a 16-bit stream.
// Word mode (in_mode=0) sends two halfword beats; LOW_FIRST sets their order.
// Half mode (in_mode=1) sends one beat narrowed to signed 16 bits. An
// overflow is flagged on that beat and latched into ovf_sticky.
// Build option: define WORD_NARROW_SAT_EN to saturate overflowing half-mode
// beats. Without it, the low halfword is passed through (truncation).
module word_narrow_16 #(
    parameter bit LOW_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        out_ovf,
    output logic        ovf_sticky,
    input  logic        ovf_clr
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BEAT0 = 2'd1;
    localparam logic [1:0] BEAT1 = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_next_s;
    logic [31:0] data_r;
    logic        mode_r;
    logic        ovf_r;
    logic        ovf_sticky_r;
    logic        accept_s;
    logic        beat_hs_s;

    // A word fits in signed 16 bits only when its upper half is pure sign extension.
    function automatic logic half_ovf(input logic [31:0] d);
        half_ovf = (d[31:16] != {16{d[15]}});
    endfunction

    // Produces the single half-mode beat from the captured word.
    function automatic logic [15:0] narrow_half(input logic [31:0] d);
`ifdef WORD_NARROW_SAT_EN
        if (half_ovf(d)) begin
            narrow_half = d[31] ? 16'h8000 : 16'h7FFF;
        end else begin
            narrow_half = d[15:0];
        end
`else
        narrow_half = d[15:0];
`endif
    endfunction

    assign in_ready   = (state_r == IDLE);
    assign out_valid  = (state_r == BEAT0) || (state_r == BEAT1);
    assign accept_s   = in_valid && in_ready;
    assign beat_hs_s  = out_valid && out_ready;
    assign ovf_sticky = ovf_sticky_r;

    // Next-state logic: a beat advances only on a downstream handshake.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = BEAT0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            BEAT0: begin
                if (out_ready) begin
                    state_next_s = mode_r ? IDLE : BEAT1;
                end else begin
                    state_next_s = BEAT0;
                end
            end
            BEAT1: begin
                if (out_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = BEAT1;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State and capture registers. A reset drops any word that is in progress.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= IDLE;
            data_r  <= 32'h0000_0000;
            mode_r  <= 1'b0;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                data_r <= in_data;
                mode_r <= in_mode;
                ovf_r  <= in_mode && half_ovf(in_data);
            end else begin
                data_r <= data_r;
                mode_r <= mode_r;
                ovf_r  <= ovf_r;
            end
        end
    end

    // Sticky overflow flag. A clear wins over a simultaneous set.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky_r <= 1'b0;
        end else if (ovf_clr) begin
            ovf_sticky_r <= 1'b0;
        end else if (beat_hs_s && out_ovf) begin
            ovf_sticky_r <= 1'b1;
        end else begin
            ovf_sticky_r <= ovf_sticky_r;
        end
    end

    // Beat decode from state and captured word. Outputs are all zero when no beat is offered.
    always_comb begin
        out_data = 16'h0000;
        out_last = 1'b0;
        out_ovf  = 1'b0;
        case (state_r)
            BEAT0: begin
                if (mode_r) begin
                    out_data = narrow_half(data_r);
                    out_last = 1'b1;
                    out_ovf  = ovf_r;
                end else begin
                    out_data = LOW_FIRST ? data_r[15:0] : data_r[31:16];
                    out_last = 1'b0;
                    out_ovf  = 1'b0;
                end
            end
            BEAT1: begin
                out_data = LOW_FIRST ? data_r[31:16] : data_r[15:0];
                out_last = 1'b1;
                out_ovf  = 1'b0;
            end
            default: begin
                out_data = 16'h0000;
                out_last = 1'b0;
                out_ovf  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_word_narrow_16.sv
// Directed bench for word_narrow_16 with its default LOW_FIRST=1.
// Inputs are driven 1 time unit after each rising edge.
// Outputs are sampled at that same point.
module tb_word_narrow_16;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic        out_ovf;
    logic        ovf_sticky;
    logic        ovf_clr;

    int total_cnt;
    int bad_cnt;

    word_narrow_16 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_mode    (in_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_clr    (ovf_clr)
    );

    // 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_beat(input string tag, input logic [15:0] d, input logic last, input logic ovf);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        check_val({tag, "_data"},  {16'd0, out_data},  {16'd0, d});
        check_val({tag, "_last"},  {31'd0, out_last},  {31'd0, last});
        check_val({tag, "_ovf"},   {31'd0, out_ovf},   {31'd0, ovf});
        check_val({tag, "_inrdy"}, {31'd0, in_ready},  32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_val({tag, "_inrdy"}, {31'd0, in_ready},  32'd1);
        check_val({tag, "_valid"}, {31'd0, out_valid}, 32'd0);
        check_val({tag, "_data"},  {16'd0, out_data},  32'd0);
        check_val({tag, "_last"},  {31'd0, out_last},  32'd0);
        check_val({tag, "_ovf"},   {31'd0, out_ovf},   32'd0);
    endtask

    // Offers one word for a single cycle. The DUT is assumed to be in IDLE.
    task automatic send(input logic [31:0] d, input logic m);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = m;
        tick();
        in_valid = 1'b0;
        in_data  = 32'h0000_0000;
        in_mode  = 1'b0;
    endtask

    logic [15:0] exp_ovf1;
    logic [15:0] exp_ovf2;

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
`ifdef WORD_NARROW_SAT_EN
        exp_ovf1 = 16'h7FFF;
        exp_ovf2 = 16'h8000;
`else
        exp_ovf1 = 16'h2345;
        exp_ovf2 = 16'h0000;
`endif
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0000_0000;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check_idle("rst");
        check_val("rst_sticky", {31'd0, ovf_sticky}, 32'd0);

        // Word mode: low half first, then high half.
        out_ready = 1'b1;
        send(32'h1234_ABCD, 1'b0);
        check_beat("w1_b0", 16'hABCD, 1'b0, 1'b0);
        tick();
        check_beat("w1_b1", 16'h1234, 1'b1, 1'b0);
        tick();
        check_idle("w1_end");

        // Half mode: the value fits, so no overflow is flagged.
        send(32'hFFFF_8000, 1'b1);
        check_beat("h1", 16'h8000, 1'b1, 1'b0);
        tick();
        check_idle("h1_end");
        check_val("h1_sticky", {31'd0, ovf_sticky}, 32'd0);

        // Half mode with overflow.
        send(32'h0001_2345, 1'b1);
        check_beat("h2", exp_ovf1, 1'b1, 1'b1);
        check_val("h2_sticky_pre", {31'd0, ovf_sticky}, 32'd0);
        tick();
        check_idle("h2_end");
        check_val("h2_sticky", {31'd0, ovf_sticky}, 32'd1);
        tick();
        check_val("h2_sticky_hold", {31'd0, ovf_sticky}, 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("h2_sticky_clr", {31'd0, ovf_sticky}, 32'd0);

        // Backpressure in BEAT0 for 5 cycles.
        out_ready = 1'b0;
        send(32'hCAFE_F00D, 1'b0);
        for (int i = 0; i < 5; i++) begin
            check_beat("bp_hold", 16'hF00D, 1'b0, 1'b0);
            tick();
        end
        check_beat("bp_hold5", 16'hF00D, 1'b0, 1'b0);
        out_ready = 1'b1;
        tick();
        check_beat("bp_b1", 16'hCAFE, 1'b1, 1'b0);
        tick();
        check_idle("bp_end");

        // Reset during BEAT1 abandons the high half. Inputs asserted during reset are ignored.
        send(32'hDEAD_BEEF, 1'b0);
        check_beat("rb_b0", 16'hBEEF, 1'b0, 1'b0);
        tick();
        check_beat("rb_b1", 16'hDEAD, 1'b1, 1'b0);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h5555_AAAA;
        tick();
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0000_0000;
        check_idle("rb_rst");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rb_no_beat", {31'd0, out_valid}, 32'd0);
        end

        // Clear and overflow set in the same cycle: the clear wins.
        send(32'h8000_0000, 1'b1);
        check_beat("cs", exp_ovf2, 1'b1, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check_val("cs_sticky", {31'd0, ovf_sticky}, 32'd0);
        check_idle("cs_end");

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
